fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences instruction fetch for the single-cycle RISC-V core: owns the fetch PC, issues requests to the instruction memory over a req/gnt/rvalid handshake, and buffers returned words.
- Presents {pc, instruction} to decode over a valid/ready interface.
- Handles branch/jump redirects, including discarding in-flight responses, and back-pressure from decode.
- Replaces free-running PC-to-memory wiring in the fetch unit.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, at least 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets on the rising edge of clk).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_WIDTH  fetch address, word aligned.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  response word valid.
- imem_rdata  input  DATA_WIDTH  response instruction word.
- redirect_valid  input  1  branch/jump taken; restart fetch.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst_data  output  DATA_WIDTH  instruction word.
- inst_pc  output  ADDR_WIDTH  address of inst_data.

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - Buffer empty, state REQ, fetch_pc=RESET_PC.
  - Reset mid-operation abandons any outstanding request. A response arriving after reset is ignored unless a new request has been granted.
- States:
  - REQ: imem_req=1 when buffer count < BUF_DEPTH. imem_addr=fetch_pc. On gnt, go to WAIT.
  - WAIT: imem_req=0. On rvalid, push {fetch_pc, rdata}, set fetch_pc+=4, go to REQ.
  - DRAIN: imem_req=0. On rvalid, discard the word and go to REQ.
- Single outstanding request at most. Memory samples imem_addr only on a gnt cycle.
- PC arithmetic:
  - fetch_pc increments by 4 modulo 2^ADDR_WIDTH. FFFF_FFFC wraps to 0000_0000.
  - redirect_pc[1:0] is forced to 0.
- Latency:
  - First cycle with rst=1 drives imem_req=1 and imem_addr=RESET_PC.
  - With gnt in cycle N and rvalid in cycle N+1, inst_valid=1 in cycle N+2.
  - The next imem_req asserts in cycle N+2.
  - Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- Buffer:
  - Synchronous FIFO. Outputs are driven from the head entry, and inst_valid = not empty.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible, because issue requires count < BUF_DEPTH.
  - inst_data and inst_pc hold stable while inst_valid=1 and inst_ready=0.
- Redirect (highest priority):
  - Flushes the buffer. inst_valid=0 next cycle, and any same-cycle inst_ready pop is ignored.
  - Sets fetch_pc=redirect_pc.
  - In REQ without gnt: imem_addr switches to the new PC next cycle, state stays REQ.
  - In REQ with gnt, or in WAIT without rvalid: go to DRAIN, because the granted/outstanding response belongs to the old PC.
  - In WAIT with rvalid: the word is discarded (no push), state goes to REQ.
  - In DRAIN: update fetch_pc only. If rvalid occurs the same cycle, discard and go to REQ.
- Back-pressure:
  - Buffer full in REQ means imem_req=0 and the state holds.
  - Request resumes the cycle after a pop frees a slot.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DRAIN}.
  - PC_INC=4, INST_NOP=32'h0000_0013.
  - Default RESET_PC.
- One sub-module, fetch_buffer: parameterised synchronous FIFO of {pc, inst}. Provides push, pop, flush, count, empty and full. Flush has priority over push and pop.

Test Plan:
- Reset then 1-cycle memory with gnt=1 and inst_ready=1 -> addresses 0,4,8,C. inst_pc/inst_data pairs match the memory image. First inst_valid arrives 2 cycles after reset release.
- Hold inst_ready=0 for 10 cycles -> exactly 2 requests issued, then imem_req=0 with buffer full. inst_data/pc stable at addr 0. Releasing ready resumes req at addr 8.
- Redirect to 0x100 in the cycle gnt accepts addr 0x8 -> word for 0x8 is discarded in DRAIN. Next request addr=0x100, and the first delivered inst_pc=0x100.
- Redirect to 0x203 while inst_valid=1 and inst_ready=1 -> buffer flushed, no pop counted. Next fetch addr=0x200.
- Redirect in REQ while gnt is held low for 3 cycles -> imem_addr changes to the target while req stays high. Granted address equals the target.
- RESET_PC=FFFF_FFF8 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting rst=0 while in WAIT returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, inst} pairs between instruction memory and decode.
// Flush wins over push and pop; a push and a pop in the same cycle are both taken.
module fetch_buffer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid transaction to instruction memory and queues words for decode.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned             BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int unsigned           BW      = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INC);
    localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(3);

    fetch_state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]       target_pc;
    logic                        issue;
    logic                        buf_push, buf_pop;
    logic                        buf_empty, buf_full;
    logic [BW-1:0]               buf_rdata;
    logic [$clog2(BUF_DEPTH):0]  buf_count;
    logic                        unused_count;

    assign target_pc    = redirect_pc & PC_MASK;
    assign issue        = rst && (state_q == REQ) && !buf_full;
    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_q;
    assign inst_valid   = !buf_empty;
    assign buf_pop      = inst_valid && inst_ready && !redirect_valid;
    assign unused_count = ^buf_count;

    // Head entry is masked while empty so decode sees zeros rather than stale words.
    assign {inst_pc, inst_data} = buf_empty ? '0 : buf_rdata;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_push   = 1'b0;
        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                    if (issue && imem_gnt) begin
                        state_d = DRAIN;
                    end
                end else if (issue && imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                    state_d    = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    buf_push   = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                // The response still in flight belongs to a squashed fetch.
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_buffer #(
        .WIDTH (BW),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc_q, imem_rdata}),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed latency/redirect/back-pressure cases, then
// random traffic scored against an address-stream model of the fetch unit.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC_A = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;

    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic        b_req, b_gnt, b_rvalid;
    logic [31:0] b_addr, b_rdata;
    logic        b_redirect_valid, b_inst_valid, b_inst_ready;
    logic [31:0] b_redirect_pc, b_inst_data, b_inst_pc;

    always #5 clk = ~clk;

    fetch_controller #(.RESET_PC(RST_PC_A)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_controller #(.RESET_PC(RST_PC_B)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .inst_valid(b_inst_valid), .inst_ready(b_inst_ready),
        .inst_data(b_inst_data), .inst_pc(b_inst_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory model for the main instance
    bit          mo_out = 0;
    logic [31:0] mo_addr = '0;
    int          mo_lat = 0;
    int          gnt_pct = 100;
    int          lat_max = 1;
    bit          gnt_block = 0;
    bit          stray_rv = 0;

    // memory model for the wrap instance (always grants, one-cycle latency)
    bit          b_pend = 0;
    logic [31:0] b_pend_addr = '0;

    // reference stream model
    logic [31:0] exp_pc = RST_PC_A, exp_req = RST_PC_A;
    logic [31:0] b_exp_pc = RST_PC_B, b_exp_req = RST_PC_B;
    bit          hold_prev = 0;
    logic [31:0] prev_pc = '0, prev_data = '0;
    int          n_accept = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic score();
        if (!rst) begin
            exp_pc    = RST_PC_A;
            exp_req   = RST_PC_A;
            hold_prev = 0;
            mo_out    = 0;
            b_exp_pc  = RST_PC_B;
            b_exp_req = RST_PC_B;
            b_pend    = 0;
        end else begin
            if (hold_prev) begin
                check_val("hold_valid", inst_valid, 1);
                check_val("hold_pc", inst_pc, prev_pc);
                check_val("hold_data", inst_data, prev_data);
            end
            if (imem_req) check_val("single_outstanding", mo_out, 0);
            if (imem_gnt) begin
                check_val("gnt_addr", imem_addr, exp_req);
                exp_req = exp_req + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end else if (inst_valid && inst_ready) begin
                check_val("deliver_pc", inst_pc, exp_pc);
                check_val("deliver_data", inst_data, img(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_accept++;
            end
            hold_prev = inst_valid && !inst_ready && !redirect_valid;
            prev_pc   = inst_pc;
            prev_data = inst_data;
            if (mo_out && mo_lat == 0) mo_out = 0;
            else if (mo_out) mo_lat--;
            if (imem_gnt) begin
                mo_out  = 1;
                mo_addr = imem_addr;
                mo_lat  = $urandom_range(lat_max - 1, 0);
            end

            if (b_gnt) begin
                check_val("wrap_gnt_addr", b_addr, b_exp_req);
                b_exp_req = b_exp_req + 32'd4;
            end
            if (b_inst_valid) begin
                check_val("wrap_pc", b_inst_pc, b_exp_pc);
                check_val("wrap_data", b_inst_data, img(b_exp_pc));
                b_exp_pc = b_exp_pc + 32'd4;
            end
            b_pend      = b_gnt;
            b_pend_addr = b_addr;
        end
    endtask

    // One clock: drive this cycle's inputs, let outputs settle, then score.
    task automatic tick(input bit rd, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        inst_ready     = rd;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rvalid    = (mo_out && mo_lat == 0) || stray_rv;
        imem_rdata     = (mo_out && mo_lat == 0) ? img(mo_addr) : $urandom;
        b_rvalid       = b_pend;
        b_rdata        = b_pend ? img(b_pend_addr) : $urandom;
        #1;
        imem_gnt = imem_req && !gnt_block && ($urandom_range(99, 0) < gnt_pct);
        b_gnt    = b_req;
        #1;
        score();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(0, 0, '0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        b_gnt = 0; b_rvalid = 0; b_rdata = '0;
        b_redirect_valid = 0; b_redirect_pc = '0; b_inst_ready = 1;

        tick(0, 0, '0);
        tick(0, 0, '0);
        check_val("rst_req", imem_req, 0);
        check_val("rst_addr", imem_addr, RST_PC_A);
        check_val("rst_valid", inst_valid, 0);
        check_val("rst_data", inst_data, 0);
        check_val("rst_pc", inst_pc, 0);
        check_val("rst_wrap_addr", b_addr, RST_PC_B);

        // sequential fetch with 1-cycle memory
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1, 0, '0);
            if (k % 2 == 0) begin
                check_val("seq_req", imem_req, 1);
                check_val("seq_addr", imem_addr, 32'(2 * k));
                if (k <= 4) check_val("wrap_seq_addr", b_addr, RST_PC_B + 32'(2 * k));
                if (k >= 2) begin
                    check_val("seq_valid", inst_valid, 1);
                    check_val("seq_pc", inst_pc, 32'(2 * k - 4));
                    check_val("seq_data", inst_data, img(32'(2 * k - 4)));
                end else begin
                    check_val("first_valid_late", inst_valid, 0);
                end
            end else begin
                check_val("seq_idle_req", imem_req, 0);
                check_val("seq_idle_valid", inst_valid, 0);
            end
        end

        // back-pressure
        do_reset();
        begin
            int reqs = 0;
            for (int i = 0; i < 10; i++) begin
                tick(0, 0, '0);
                if (imem_req && imem_gnt) reqs++;
            end
            check_val("bp_req_count", reqs, 2);
        end
        check_val("bp_req_off", imem_req, 0);
        check_val("bp_valid", inst_valid, 1);
        check_val("bp_pc", inst_pc, 0);
        check_val("bp_data", inst_data, img(0));
        tick(1, 0, '0);
        check_val("bp_still_full", imem_req, 0);
        tick(1, 0, '0);
        check_val("bp_resume_req", imem_req, 1);
        check_val("bp_resume_addr", imem_addr, 32'h8);

        // redirect in the cycle 0x8 is granted, then redirect while popping
        do_reset();
        for (int k = 0; k < 4; k++) tick(1, 0, '0);
        tick(1, 1, 32'h100);
        check_val("rd_gnt", imem_gnt, 1);
        check_val("rd_gnt_addr", imem_addr, 32'h8);
        tick(1, 0, '0);
        check_val("rd_flush_valid", inst_valid, 0);
        check_val("rd_drain_req", imem_req, 0);
        tick(1, 0, '0);
        check_val("rd_new_req", imem_req, 1);
        check_val("rd_new_addr", imem_addr, 32'h100);
        check_val("rd_no_old_word", inst_valid, 0);
        tick(1, 0, '0);
        tick(1, 1, 32'h203);
        check_val("rd_first_valid", inst_valid, 1);
        check_val("rd_first_pc", inst_pc, 32'h100);
        check_val("rd_first_data", inst_data, img(32'h100));
        tick(1, 0, '0);
        check_val("rd2_flush_valid", inst_valid, 0);
        tick(1, 0, '0);
        check_val("rd2_addr", imem_addr, 32'h200);
        check_val("rd2_req", imem_req, 1);
        tick(1, 0, '0);
        tick(1, 0, '0);
        check_val("rd2_pc", inst_pc, 32'h200);

        // redirect in REQ with grant withheld, then reset while WAIT
        do_reset();
        gnt_block = 1;
        tick(1, 0, '0);
        check_val("rq_addr0", imem_addr, 32'h0);
        tick(1, 1, 32'h340);
        check_val("rq_req_held", imem_req, 1);
        check_val("rq_addr_old", imem_addr, 32'h0);
        tick(1, 0, '0);
        check_val("rq_req_held2", imem_req, 1);
        check_val("rq_addr_new", imem_addr, 32'h340);
        gnt_block = 0;
        tick(1, 0, '0);
        check_val("rq_gnt", imem_gnt, 1);
        check_val("rq_gnt_addr", imem_addr, 32'h340);
        rst = 1'b0;
        tick(1, 0, '0);
        tick(1, 0, '0);
        check_val("mid_rst_req", imem_req, 0);
        check_val("mid_rst_addr", imem_addr, RST_PC_A);
        check_val("mid_rst_valid", inst_valid, 0);
        check_val("mid_rst_data", inst_data, 0);
        check_val("mid_rst_pc", inst_pc, 0);
        rst = 1'b1;
        gnt_block = 1;
        stray_rv = 1;
        tick(1, 0, '0);
        check_val("post_rst_req", imem_req, 1);
        check_val("post_rst_addr", imem_addr, RST_PC_A);
        stray_rv = 0;
        tick(1, 0, '0);
        check_val("stray_ignored", inst_valid, 0);
        gnt_block = 0;

        // random traffic
        do_reset();
        gnt_pct  = 60;
        lat_max  = 3;
        n_accept = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          rd, rdr;
            logic [31:0] tgt;
            rd  = ($urandom_range(99, 0) < 70);
            rdr = ($urandom_range(99, 0) < 5);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_0FFF);
            tick(rd, rdr, tgt);
        end
        check_val("rand_progress", 32'(n_accept > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
